// File: rtl/issue_gate.sv
// Single-entry in-order issue stage: holds one decoded instruction, stalls it on
// RAW hazards against the scoreboard lock bitmap, and emits the destination lock on issue.
module issue_gate #(
  parameter int XWDT = 6,
  parameter int XN   = 64,
  parameter int PW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XWDT-1:0] in_rs1,
  input  logic [XWDT-1:0] in_rs2,
  input  logic [XWDT-1:0] in_rd,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic [PW-1:0]   in_payload,
  input  logic            flush,
  input  logic [XN-1:0]   rlocks,
  output logic [XWDT-1:0] rset,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XWDT-1:0] out_rd,
  output logic [PW-1:0]   out_payload,
  output logic [15:0]     stall_cnt
);

  logic            s_valid_q, s_valid_d;
  logic [XWDT-1:0] s_rs1_q, s_rs2_q, s_rd_q;
  logic            s_use_rs1_q, s_use_rs2_q;
  logic [PW-1:0]   s_payload_q;
  logic            out_valid_q, out_valid_d;
  logic [XWDT-1:0] out_rd_q;
  logic [PW-1:0]   out_payload_q;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic hazard, out_free, fire, accept;

  // Register 0 is never a real dependency, so its lock bit is ignored.
  always_comb begin
    hazard   = s_valid_q &&
               ((s_use_rs1_q && (s_rs1_q != '0) && rlocks[s_rs1_q]) ||
                (s_use_rs2_q && (s_rs2_q != '0) && rlocks[s_rs2_q]));
    out_free = !out_valid_q || out_ready;
    fire     = s_valid_q && !hazard && out_free && !flush;
    in_ready = !flush && (!s_valid_q || fire);
    accept   = in_valid && in_ready;
    rset     = fire ? s_rd_q : '0;
  end

  always_comb begin
    s_valid_d   = s_valid_q;
    out_valid_d = out_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush)       s_valid_d = 1'b0;
    else if (accept) s_valid_d = 1'b1;
    else if (fire)   s_valid_d = 1'b0;
    if (fire)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    if (hazard && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_payload_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      s_valid_q   <= s_valid_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (fire) begin
        out_rd_q      <= s_rd_q;
        out_payload_q <= s_payload_q;
      end
    end
  end

  // Slot fields need no reset; they are qualified by s_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_rs1_q     <= in_rs1;
      s_rs2_q     <= in_rs2;
      s_rd_q      <= in_rd;
      s_use_rs1_q <= in_use_rs1;
      s_use_rs2_q <= in_use_rs2;
      s_payload_q <= in_payload;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_payload = out_payload_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_issue_gate.sv
// Directed vector bench for issue_gate: each row is one cycle of inputs plus the
// outputs expected during that cycle (before the next rising edge).
module tb_issue_gate;

  localparam int XWDT = 6, XN = 64, PW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [XWDT-1:0] in_rs1, in_rs2, in_rd, rset, out_rd;
  logic            in_use_rs1, in_use_rs2, flush;
  logic [PW-1:0]   in_payload, out_payload;
  logic [XN-1:0]   rlocks;
  logic            out_valid, out_ready;
  logic [15:0]     stall_cnt;

  int errors = 0;
  int checks = 0;

  issue_gate #(.XWDT(XWDT), .XN(XN), .PW(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_payload(in_payload),
    .flush(flush), .rlocks(rlocks), .rset(rset),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    int          rs1, rs2, rd;
    bit          u1, u2;
    int          pl;
    bit          fl;
    logic [63:0] lk;
    bit          ordy;
    bit          e_irdy;
    int          e_rset;
    bit          e_ov;
    int          e_ord;
    int          e_opl;
    int          e_sc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t V(bit iv, int rs1, int rs2, int rd, bit u1, bit u2, int pl,
                             bit fl, logic [63:0] lk, bit ordy,
                             bit e_irdy, int e_rset, bit e_ov, int e_ord, int e_opl, int e_sc);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.pl = pl;
    v.fl = fl; v.lk = lk; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_rset = e_rset; v.e_ov = e_ov; v.e_ord = e_ord;
    v.e_opl = e_opl; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.iv;
    in_rs1     = XWDT'(v.rs1);
    in_rs2     = XWDT'(v.rs2);
    in_rd      = XWDT'(v.rd);
    in_use_rs1 = v.u1;
    in_use_rs2 = v.u2;
    in_payload = PW'(v.pl);
    flush      = v.fl;
    rlocks     = v.lk;
    out_ready  = v.ordy;
  endtask

  localparam logic [63:0] L0  = 64'h0;
  localparam logic [63:0] L3  = 64'h8;
  localparam logic [63:0] L09 = 64'h201;

  initial begin
    // iv rs1 rs2 rd u1 u2 pl fl lk ordy | irdy rset ov ord opl sc
    // independent stream rd=5,6,7
    vq.push_back(V(1,0,0, 5,0,0,'hA5,0,L0,1, 1, 0,0, 0,  0,0));
    vq.push_back(V(1,0,0, 6,0,0,'hA6,0,L0,1, 1, 5,0, 0,  0,0));
    vq.push_back(V(1,0,0, 7,0,0,'hA7,0,L0,1, 1, 6,1, 5,'hA5,0));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1, 7,1, 6,'hA6,0));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1, 0,1, 7,'hA7,0));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1, 0,0, 7,  0,0));
    // RAW stall on r3 for four cycles, then release
    vq.push_back(V(1,3,0,10,1,0,'hB0,0,L3,1, 1, 0,0, 7,  0,0));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L3,1, 0, 0,0, 7,  0,0));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L3,1, 0, 0,0, 7,  0,1));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L3,1, 0, 0,0, 7,  0,2));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L3,1, 0, 0,0, 7,  0,3));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1,10,0, 7,  0,4));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1, 0,1,10,'hB0,4));
    // x0 source with lock bit 0 set, unused rs2=9 locked
    vq.push_back(V(1,0,9,12,1,0,'hC0,0,L09,1,1, 0,0,10,  0,4));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L09,1,1,12,0,10,  0,4));
    // backpressure: hold, then fire in the same cycle out_ready rises
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,0, 1, 0,1,12,'hC0,4));
    vq.push_back(V(1,0,0,13,0,0,'hD0,0,L0,0, 1, 0,1,12,'hC0,4));
    vq.push_back(V(1,0,0,14,0,0,'hD1,0,L0,0, 0, 0,1,12,'hC0,4));
    vq.push_back(V(1,0,0,14,0,0,'hD1,0,L0,1, 1,13,1,12,'hC0,4));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1,14,1,13,'hD0,4));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,0, 1, 0,1,14,'hD1,4));
    // flush while stalled, with a competing input that must be refused
    vq.push_back(V(1,3,0,20,1,0,'hE0,0,L3,0, 1, 0,1,14,'hD1,4));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L3,0, 0, 0,1,14,'hD1,4));
    vq.push_back(V(1,0,0,21,0,0,'hE1,1,L3,1, 0, 0,1,14,'hD1,5));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1, 0,0,14,  0,5));
    vq.push_back(V(0,0,0, 0,0,0,    0,0,L0,1, 1, 0,0,14,  0,5));

    // reset for two cycles with an offered instruction
    drive(V(1,0,0,31,0,0,'h55,0,L0,1, 0,0,0,0,0,0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready",  in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset rset",      rset, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset out_rd",    out_rd, 0);

    foreach (vq[i]) begin
      if (i > 0) @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d in_ready", i),  in_ready,  vq[i].e_irdy);
      chk($sformatf("v%0d rset", i),      rset,      vq[i].e_rset);
      chk($sformatf("v%0d out_valid", i), out_valid, vq[i].e_ov);
      chk($sformatf("v%0d out_rd", i),    out_rd,    vq[i].e_ord);
      if (vq[i].e_ov) chk($sformatf("v%0d out_payload", i), out_payload, vq[i].e_opl);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, vq[i].e_sc);
    end

    // saturation: 70000 stall cycles starting from a count of 5
    @(negedge clk);
    drive(V(1,3,0,30,1,0,'hF0,0,L3,1, 0,0,0,0,0,0));
    @(negedge clk);
    drive(V(0,0,0,0,0,0,0,0,L3,1, 0,0,0,0,0,0));
    repeat (70000) @(negedge clk);
    #1;
    chk("sat stall_cnt", stall_cnt, 16'hFFFF);
    chk("sat in_ready",  in_ready, 0);
    chk("sat rset",      rset, 0);
    @(negedge clk);
    #1;
    chk("sat hold stall_cnt", stall_cnt, 16'hFFFF);
    // flush the stalled instruction, then release the lock: nothing may issue
    flush = 1'b1;
    #1;
    chk("sat flush rset", rset, 0);
    @(negedge clk);
    flush = 1'b0;
    rlocks = '0;
    #1;
    chk("post flush rset", rset, 0);
    chk("post flush in_ready", in_ready, 1);

    // reset mid-operation clears the counter and drops the slot
    drive(V(1,0,0,40,0,0,'h77,0,L0,0, 0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst2 stall_cnt", stall_cnt, 0);
    chk("rst2 rset",      rset, 0);
    chk("rst2 out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
